toy_dog_ctrl: RTL and testbench



---
 rtl/toy_dog_pkg.sv | 26 ++
 rtl/toy_dog_ctrl_edge_sync.sv | 48 ++++
 rtl/toy_dog_ctrl.sv | 147 ++++++++++++++
 tb/tb_toy_dog_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toy_dog_pkg.sv
// toy_dog_pkg: shared state type and mood code constants for the toy dog controller.
// The enum values are the mood codes themselves, so mood == state code.
// Consumers decoding mood (the 7-segment mood decoder) import the MOOD_* constants.
package toy_dog_pkg;

  typedef enum logic [2:0] {
    ST_SLEEP  = 3'b000,
    ST_IDLE   = 3'b001,
    ST_HAPPY  = 3'b010,
    ST_HUNGRY = 3'b011,
    ST_EATING = 3'b100,
    ST_BARK   = 3'b101
  } state_e;

  localparam logic [2:0] MOOD_SLEEP  = 3'b000;
  localparam logic [2:0] MOOD_IDLE   = 3'b001;
  localparam logic [2:0] MOOD_HAPPY  = 3'b010;
  localparam logic [2:0] MOOD_HUNGRY = 3'b011;
  localparam logic [2:0] MOOD_EATING = 3'b100;
  localparam logic [2:0] MOOD_BARK   = 3'b101;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/toy_dog_ctrl_edge_sync.sv
// edge_sync: turns a level sensor input into a single-cycle rising-edge pulse.
// Latency: 2 cycles with TOY_DOG_SYNC_EN (2-flop synchronizer), else combinational from din.
// Ports: clk, rst_n (async active-low), din (level in), pulse (one cycle high per 0->1 of din).
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic lvl;
  logic prev_q, prev_d;

`ifdef TOY_DOG_SYNC_EN
  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign lvl = sync_q;
`else
  assign lvl = din;
`endif

  always_comb prev_d = lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  // A held level only produces a pulse on its first cycle.
  assign pulse = lvl & ~prev_q;

endmodule

// File: rtl/toy_dog_ctrl.sv
// toy_dog_ctrl: timed Moore FSM driving mood code, tail motor and buzzer from pet/feed/prox sensors.
// Ports: clk, rst_n (async active-low); pet, feed, prox level inputs; mood[2:0], tail, bark registered outputs.
// Build option TOY_DOG_SYNC_EN: synchronize sensor inputs (events act 2 cycles later); default treats them as synchronous.
module toy_dog_ctrl import toy_dog_pkg::*; #(
  parameter int CLK_PER_SEC = 50_000_000,
  parameter int IDLE_SEC    = 10,
  parameter int HAPPY_SEC   = 3,
  parameter int BARK_SEC    = 2,
  parameter int EAT_SEC     = 4,
  parameter int HUNGER_SEC  = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pet,
  input  logic       feed,
  input  logic       prox,
  output logic [2:0] mood,
  output logic       tail,
  output logic       bark
);

  localparam int PW      = $clog2(CLK_PER_SEC);
  localparam int MAX_SEC = max_int(max_int(max_int(IDLE_SEC, HAPPY_SEC),
                                           max_int(BARK_SEC, EAT_SEC)), HUNGER_SEC);
  localparam int SW      = $clog2(MAX_SEC + 1);

  logic pet_p, feed_p, prox_p;

  edge_sync u_pet  (.clk(clk), .rst_n(rst_n), .din(pet),  .pulse(pet_p));
  edge_sync u_feed (.clk(clk), .rst_n(rst_n), .din(feed), .pulse(feed_p));
  edge_sync u_prox (.clk(clk), .rst_n(rst_n), .din(prox), .pulse(prox_p));

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] elapsed_q, elapsed_d;
  logic [SW-1:0] hunger_q, hunger_d;
  logic          phase_q, phase_d;
  logic [2:0]    mood_q, mood_d;
  logic          tail_q, tail_d;
  logic          bark_q, bark_d;

  logic sec_tick, state_chg, hunger_full;
  logic idle_done, happy_done, bark_done, eat_done;

  assign sec_tick    = (presc_q == PW'(CLK_PER_SEC - 1));
  assign hunger_full = (hunger_q == SW'(HUNGER_SEC));

  // A dwell of N seconds ends on the tick that would make elapsed reach N, so the
  // exit edge lands exactly N*CLK_PER_SEC cycles after the entry edge.
  assign idle_done  = sec_tick && (elapsed_q == SW'(IDLE_SEC - 1));
  assign happy_done = sec_tick && (elapsed_q == SW'(HAPPY_SEC - 1));
  assign bark_done  = sec_tick && (elapsed_q == SW'(BARK_SEC - 1));
  assign eat_done   = sec_tick && (elapsed_q == SW'(EAT_SEC - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SLEEP: begin
        if (feed_p)               state_d = ST_EATING;
        else if (pet_p || prox_p) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (feed_p)           state_d = ST_EATING;
        else if (hunger_full) state_d = ST_HUNGRY;
        else if (pet_p)       state_d = ST_HAPPY;
        else if (prox_p)      state_d = ST_BARK;
        else if (idle_done)   state_d = ST_SLEEP;
      end
      ST_HAPPY: begin
        if (feed_p)          state_d = ST_EATING;
        else if (happy_done) state_d = ST_IDLE;
      end
      ST_BARK: begin
        if (feed_p)         state_d = ST_EATING;
        else if (bark_done) state_d = ST_IDLE;
      end
      ST_EATING: begin
        if (eat_done) state_d = ST_IDLE;
      end
      ST_HUNGRY: begin
        if (feed_p) state_d = ST_EATING;
      end
      default: state_d = ST_SLEEP;
    endcase
  end

  assign state_chg = (state_d != state_q);

  always_comb begin
    presc_d   = presc_q + 1'b1;
    elapsed_d = elapsed_q;
    hunger_d  = hunger_q;
    phase_d   = phase_q;

    // Every state change restarts the one-second grid for the new state.
    if (state_chg || sec_tick) presc_d = '0;

    if (state_chg)
      elapsed_d = '0;
    else if (sec_tick && (elapsed_q != SW'(MAX_SEC)))
      elapsed_d = elapsed_q + 1'b1;

    if ((state_d == ST_EATING) && (state_q != ST_EATING))
      hunger_d = '0;
    else if (sec_tick && (state_q != ST_EATING) && !hunger_full)
      hunger_d = hunger_q + 1'b1;

    // Whimper pattern in HUNGRY: buzzer on at entry, flips every second.
    if ((state_d == ST_HUNGRY) && (state_q != ST_HUNGRY))
      phase_d = 1'b1;
    else if ((state_q == ST_HUNGRY) && sec_tick)
      phase_d = ~phase_q;
  end

  always_comb begin
    mood_d = state_d;
    tail_d = (state_d == ST_HAPPY) || (state_d == ST_EATING);
    bark_d = (state_d == ST_BARK) || ((state_d == ST_HUNGRY) && phase_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SLEEP;
      presc_q   <= '0;
      elapsed_q <= '0;
      hunger_q  <= '0;
      phase_q   <= 1'b0;
      mood_q    <= MOOD_SLEEP;
      tail_q    <= 1'b0;
      bark_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      elapsed_q <= elapsed_d;
      hunger_q  <= hunger_d;
      phase_q   <= phase_d;
      mood_q    <= mood_d;
      tail_q    <= tail_d;
      bark_q    <= bark_d;
    end
  end

  assign mood = mood_q;
  assign tail = tail_q;
  assign bark = bark_q;

endmodule

// File: tb/tb_toy_dog_ctrl.sv
module tb_toy_dog_ctrl;

  localparam int CPS      = 4;
  localparam int IDLE_S   = 2;
  localparam int HAPPY_S  = 3;
  localparam int BARK_S   = 2;
  localparam int EAT_S    = 4;
  localparam int HUNGER_S = 3;
`ifdef TOY_DOG_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  localparam logic [2:0] C_SLEEP  = 3'd0;
  localparam logic [2:0] C_IDLE   = 3'd1;
  localparam logic [2:0] C_HAPPY  = 3'd2;
  localparam logic [2:0] C_HUNGRY = 3'd3;
  localparam logic [2:0] C_EATING = 3'd4;
  localparam logic [2:0] C_BARK   = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pet = 1'b0, feed = 1'b0, prox = 1'b0;
  logic [2:0] mood;
  logic       tail, bark;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  toy_dog_ctrl #(
    .CLK_PER_SEC(CPS), .IDLE_SEC(IDLE_S), .HAPPY_SEC(HAPPY_S),
    .BARK_SEC(BARK_S), .EAT_SEC(EAT_S), .HUNGER_SEC(HUNGER_S)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pet(pet), .feed(feed), .prox(prox),
    .mood(mood), .tail(tail), .bark(bark)
  );

  // Reference model: time in state counted in raw cycles, events delayed by LAT.
  int         m_st, m_cyc, m_hunger;
  bit         m_phase;
  logic [2:0] m_prev, m_dl0, m_dl1;
  logic [2:0] exp_mood;
  logic       exp_tail, exp_bark;

  always @(posedge clk or negedge rst_n) begin : model
    logic [2:0] lv, ev, use_ev;
    int nxt;
    bit tick, ep, ef, ex;
    if (!rst_n) begin
      m_st = 0; m_cyc = 0; m_hunger = 0; m_phase = 0;
      m_prev = '0; m_dl0 = '0; m_dl1 = '0;
      exp_mood = 3'd0; exp_tail = 1'b0; exp_bark = 1'b0;
    end else begin
      lv = {pet, feed, prox};
      ev = lv & ~m_prev;
      m_prev = lv;
      if (LAT == 0) use_ev = ev;
      else begin use_ev = m_dl1; m_dl1 = m_dl0; m_dl0 = ev; end
      ep = use_ev[2]; ef = use_ev[1]; ex = use_ev[0];
      tick = ((m_cyc % CPS) == CPS - 1);
      nxt = m_st;
      case (m_st)
        0: if (ef) nxt = 4; else if (ep || ex) nxt = 1;
        1: if (ef) nxt = 4; else if (m_hunger == HUNGER_S) nxt = 3;
           else if (ep) nxt = 2; else if (ex) nxt = 5;
           else if (m_cyc + 1 == IDLE_S * CPS) nxt = 0;
        2: if (ef) nxt = 4; else if (m_cyc + 1 == HAPPY_S * CPS) nxt = 1;
        5: if (ef) nxt = 4; else if (m_cyc + 1 == BARK_S * CPS) nxt = 1;
        4: if (m_cyc + 1 == EAT_S * CPS) nxt = 1;
        3: if (ef) nxt = 4;
        default: nxt = 0;
      endcase
      if (nxt == 4 && m_st != 4) m_hunger = 0;
      else if (tick && m_st != 4 && m_hunger < HUNGER_S) m_hunger++;
      if (nxt == 3 && m_st != 3) m_phase = 1;
      else if (m_st == 3 && tick) m_phase = !m_phase;
      m_cyc = (nxt != m_st) ? 0 : m_cyc + 1;
      m_st = nxt;
      exp_mood = 3'(m_st);
      exp_tail = (m_st == 2) || (m_st == 4);
      exp_bark = (m_st == 5) || (m_st == 3 && m_phase);
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; pet = 0; feed = 0; prox = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #2;
    checks++;
    if ({mood, tail, bark} !== 5'b0) begin
      errors++; $display("FAIL reset_async mood/tail/bark=%b want 00000", {mood, tail, bark});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (mood !== exp_mood || tail !== exp_tail || bark !== exp_bark || mood !== C_SLEEP) begin
        errors++; $display("FAIL reset_idle mood=%b tail=%b bark=%b want mood=%b tail=%b bark=%b",
                           mood, tail, bark, C_SLEEP, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic test_pet_happy();
    int tail_cnt = 0;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      pet = (i == 0 || i == 4);
      @(posedge clk); #1;
      checks++;
      if (mood !== exp_mood || tail !== exp_tail || bark !== exp_bark) begin
        errors++; $display("FAIL pet_happy_model i=%0d mood=%b tail=%b bark=%b want %b %b %b",
                           i, mood, tail, bark, exp_mood, exp_tail, exp_bark);
      end
      if (tail === 1'b1) tail_cnt++;
      if (i == LAT) begin
        checks++;
        if (mood !== C_IDLE) begin errors++; $display("FAIL pet_wake mood=%b want %b", mood, C_IDLE); end
      end
      if (i == 4 + LAT) begin
        checks++;
        if (mood !== C_HAPPY || tail !== 1'b1) begin
          errors++; $display("FAIL pet_happy_entry mood=%b tail=%b want %b 1", mood, tail, C_HAPPY);
        end
      end
      if (i == 16 + LAT) begin
        checks++;
        if (mood !== C_IDLE || tail !== 1'b0) begin
          errors++; $display("FAIL happy_exit mood=%b tail=%b want %b 0", mood, tail, C_IDLE);
        end
      end
    end
    pet = 0;
    checks++;
    if (tail_cnt != HAPPY_S * CPS) begin
      errors++; $display("FAIL happy_tail_cycles got %0d want %0d", tail_cnt, HAPPY_S * CPS);
    end
  endtask

  task automatic test_hungry_eat_timeout();
    do_reset();
    for (int i = 0; i < 60; i++) begin
      pet  = (i == 16 || i == 20);
      feed = (i == 30);
      @(posedge clk); #1;
      checks++;
      if (mood !== exp_mood || tail !== exp_tail || bark !== exp_bark) begin
        errors++; $display("FAIL hungry_model i=%0d mood=%b tail=%b bark=%b want %b %b %b",
                           i, mood, tail, bark, exp_mood, exp_tail, exp_bark);
      end
      if (i >= 17 + LAT && i < 29 + LAT) begin
        checks++;
        if (mood !== C_HUNGRY || bark !== ((((i - 17 - LAT) / CPS) % 2) == 0)) begin
          errors++; $display("FAIL hungry_bark i=%0d mood=%b bark=%b want %b %b", i, mood, bark,
                             C_HUNGRY, ((((i - 17 - LAT) / CPS) % 2) == 0));
        end
      end
      if (i == 30 + LAT || i == 45 + LAT) begin
        checks++;
        if (mood !== C_EATING || tail !== 1'b1) begin
          errors++; $display("FAIL eating i=%0d mood=%b tail=%b want %b 1", i, mood, tail, C_EATING);
        end
      end
      if (i == 46 + LAT || i == 53 + LAT) begin
        checks++;
        if (mood !== C_IDLE) begin errors++; $display("FAIL eat_to_idle i=%0d mood=%b want %b", i, mood, C_IDLE); end
      end
      if (i == 54 + LAT) begin
        checks++;
        if (mood !== C_SLEEP) begin errors++; $display("FAIL idle_timeout mood=%b want %b", mood, C_SLEEP); end
      end
    end
    pet = 0; feed = 0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 45; i++) begin
      feed = (i == 0 || i == 20 || i == 37);
      pet  = (i == 17);
      prox = (i == 17 || i == 37);
      @(posedge clk); #1;
      checks++;
      if (mood !== exp_mood || tail !== exp_tail || bark !== exp_bark) begin
        errors++; $display("FAIL simul_model i=%0d mood=%b tail=%b bark=%b want %b %b %b",
                           i, mood, tail, bark, exp_mood, exp_tail, exp_bark);
      end
      if (i == 17 + LAT) begin
        checks++;
        if (mood !== C_HAPPY) begin errors++; $display("FAIL pet_prox_same mood=%b want %b", mood, C_HAPPY); end
      end
      if (i == 37 + LAT) begin
        checks++;
        if (mood !== C_EATING) begin errors++; $display("FAIL feed_prox_same mood=%b want %b", mood, C_EATING); end
      end
    end
    feed = 0; pet = 0; prox = 0;
  endtask

  task automatic test_held_prox();
    int bark_cnt = 0;
    do_reset();
    for (int i = 0; i < 72; i++) begin
      feed = (i == 0 || i == 42 || i == 67);
      prox = (i >= 17 && i < 40) || (i == 59);
      @(posedge clk); #1;
      checks++;
      if (mood !== exp_mood || tail !== exp_tail || bark !== exp_bark) begin
        errors++; $display("FAIL held_prox_model i=%0d mood=%b tail=%b bark=%b want %b %b %b",
                           i, mood, tail, bark, exp_mood, exp_tail, exp_bark);
      end
      if (i < 50 && mood === C_BARK) bark_cnt++;
      if (i == 16 + LAT) begin
        checks++;
        if (mood !== C_IDLE) begin errors++; $display("FAIL prox_latency_early mood=%b want %b", mood, C_IDLE); end
      end
      if (i == 17 + LAT) begin
        checks++;
        if (mood !== C_BARK || bark !== 1'b1) begin
          errors++; $display("FAIL prox_latency mood=%b bark=%b want %b 1", mood, bark, C_BARK);
        end
      end
      if (i == 67 + LAT) begin
        checks++;
        if (mood !== C_EATING) begin errors++; $display("FAIL timeout_vs_feed mood=%b want %b", mood, C_EATING); end
      end
    end
    feed = 0; prox = 0;
    checks++;
    if (bark_cnt != BARK_S * CPS) begin
      errors++; $display("FAIL held_prox_bark_cycles got %0d want %0d", bark_cnt, BARK_S * CPS);
    end
  endtask

  task automatic test_reset_mid_bark();
    do_reset();
    for (int i = 0; i < 21 + LAT; i++) begin
      feed = (i == 0);
      prox = (i == 17);
      @(posedge clk); #1;
    end
    checks++;
    if (mood !== C_BARK) begin errors++; $display("FAIL pre_reset_bark mood=%b want %b", mood, C_BARK); end
    #2 rst_n = 1'b0; feed = 0; prox = 0;
    #1;
    checks++;
    if ({mood, tail, bark} !== 5'b0) begin
      errors++; $display("FAIL reset_mid_bark mood/tail/bark=%b want 00000", {mood, tail, bark});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (mood !== C_SLEEP || tail !== 1'b0 || bark !== 1'b0) begin
        errors++; $display("FAIL after_reset_sleep i=%0d mood=%b tail=%b bark=%b want 000 0 0", i, mood, tail, bark);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) pet  = ~pet;
      if ($urandom_range(9) == 0) feed = ~feed;
      if ($urandom_range(5) == 0) prox = ~prox;
      rst_n = ($urandom_range(399) != 0);
      @(posedge clk); #1;
      checks++;
      if (mood !== exp_mood || tail !== exp_tail || bark !== exp_bark) begin
        errors++; $display("FAIL random i=%0d mood=%b tail=%b bark=%b want %b %b %b",
                           i, mood, tail, bark, exp_mood, exp_tail, exp_bark);
      end
    end
    rst_n = 1'b1; pet = 0; feed = 0; prox = 0;
  endtask

  initial begin
    test_reset();
    test_pet_happy();
    test_hungry_eat_timeout();
    test_simultaneous();
    test_held_prox();
    test_reset_mid_bark();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
